// File: rtl/lcd_vtiming_pkg.sv
// +----------------------------------------------------------------------------+
// | lcd_vtiming_pkg                                                            |
// | Shared vertical-timing state encodings, default panel constants, clogb2.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package lcd_vtiming_pkg;

    localparam int H_TOTAL_DEF     = 1056;
    localparam int H_DEN_START_DEF = 216;
    localparam int H_DEN_END_DEF   = 1016;
    localparam int H_ACTIVE_DEF    = H_DEN_END_DEF - H_DEN_START_DEF;

    localparam int V_TOTAL_DEF     = 525;
    localparam int VBP_DEF         = 35;
    localparam int VFP_DEF         = 515;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BACK   = 2'd1,
        ACTIVE = 2'd2,
        FRONT  = 2'd3
    } vstate_t;

    // Bits needed to hold the value itself (never less than one).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_vtiming_hd_edge_watch.sv
// +----------------------------------------------------------------------------+
// | hd_edge_watch                                                              |
// | HD falling-edge detector; with HD_WATCHDOG_EN, a sticky lost-HD timeout.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hd_edge_watch
    import lcd_vtiming_pkg::*;
`ifdef HD_WATCHDOG_EN
#(
    parameter int H_TOTAL = H_TOTAL_DEF
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic hd,
`ifdef HD_WATCHDOG_EN
    output logic hd_lost,
`endif
    output logic line_evt
);

    logic hd_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hd_q <= 1'b1;
        end else begin
            hd_q <= hd;
        end
    end

    // One event per line, however long HD stays low.
    assign line_evt = hd_q & ~hd;

`ifdef HD_WATCHDOG_EN
    localparam int            WD_W     = clogb2(2 * H_TOTAL);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(2 * H_TOTAL - 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt  <= '0;
            hd_lost <= 1'b0;
        end else if (line_evt) begin
            wd_cnt  <= '0;
            hd_lost <= 1'b0;
        end else begin
            if (wd_cnt != WD_LIMIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt == WD_LIMIT) begin
                hd_lost <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/lcd_vtiming.sv
// +----------------------------------------------------------------------------+
// | lcd_vtiming                                                                |
// | Vertical timing: VD, frame DEN, LINE/ROW/COL indices, frame-start strobe.  |
// | Optional macro HD_WATCHDOG_EN adds the HD_LOST timeout output.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_vtiming
    import lcd_vtiming_pkg::*;
#(
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int VBP      = VBP_DEF,
    parameter int VFP      = VFP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF
)
(
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                HD,
    input  logic                                DEN_H,
    output logic                                VD,
    output logic                                DEN,
    output logic [clogb2(V_TOTAL-1)-1:0]        LINE,
    output logic [clogb2(VFP-VBP-1)-1:0]        ROW,
    output logic [clogb2(H_ACTIVE-1)-1:0]       COL,
`ifdef HD_WATCHDOG_EN
    output logic                                HD_LOST,
`endif
    output logic                                FRAME_START
);

    localparam int LINE_W = clogb2(V_TOTAL-1);
    localparam int ROW_W  = clogb2(VFP-VBP-1);
    localparam int COL_W  = clogb2(H_ACTIVE-1);

    // A line can never hold more pixels than it has clocks.
    localparam int COL_LAST = ((H_ACTIVE < H_TOTAL) ? H_ACTIVE : H_TOTAL) - 1;

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_TOTAL - 1);
    localparam logic [LINE_W-1:0] FIRST_ACT = LINE_W'(VBP);
    localparam logic [LINE_W-1:0] FIRST_FP  = LINE_W'(VFP);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COL_LAST);

    logic              line_evt;
    logic              lost;
    vstate_t           state;
    vstate_t           state_base;
    vstate_t           state_next;
    logic [LINE_W-1:0] line_base;
    logic [LINE_W-1:0] line_next;

`ifdef HD_WATCHDOG_EN
    hd_edge_watch #(
        .H_TOTAL (H_TOTAL)
    ) u_hd_edge_watch (
        .clock    (clock),
        .reset    (reset),
        .hd       (HD),
        .hd_lost  (lost),
        .line_evt (line_evt)
    );
    assign HD_LOST = lost;
`else
    hd_edge_watch u_hd_edge_watch (
        .clock    (clock),
        .reset    (reset),
        .hd       (HD),
        .line_evt (line_evt)
    );
    assign lost = 1'b0;
`endif

    // A lost HD parks the frame at the last line so the next event restarts at 0.
    always_comb begin
        line_base  = lost ? LAST_LINE : LINE;
        state_base = lost ? FRONT : state;
        line_next  = line_base;
        if (line_evt) begin
            line_next = (line_base == LAST_LINE) ? '0 : line_base + 1'b1;
        end
        state_next = state_base;
        case (state_base)
            SYNC:   if (line_next != '0)
                        state_next = (line_next >= FIRST_ACT) ? ACTIVE : BACK;
            BACK:   if (line_next >= FIRST_ACT) state_next = ACTIVE;
            ACTIVE: if (line_next >= FIRST_FP)  state_next = FRONT;
            FRONT:  if (line_next == '0)        state_next = SYNC;
            default: state_next = FRONT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FRONT;
            LINE        <= LAST_LINE;
            VD          <= 1'b1;
            DEN         <= 1'b0;
            ROW         <= '0;
            COL         <= '0;
            FRAME_START <= 1'b0;
        end else begin
            state       <= state_next;
            LINE        <= line_next;
            VD          <= (line_next != '0);
            FRAME_START <= line_evt && (line_next == '0);
            DEN         <= DEN_H && (state_next == ACTIVE);
            if (state_next == ACTIVE) begin
                ROW <= ROW_W'(line_next - FIRST_ACT);
            end else begin
                ROW <= '0;
            end
            if (DEN_H && (state_next == ACTIVE)) begin
                if (!DEN) begin
                    COL <= '0;
                end else begin
                    COL <= (COL == COL_MAX) ? COL_MAX : COL + 1'b1;
                end
            end else begin
                COL <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_vtiming.sv
// +----------------------------------------------------------------------------+
// | tb_lcd_vtiming                                                             |
// | Directed bench for lcd_vtiming on a reduced 10-line, 12-clock raster.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_vtiming;

    localparam int V_TOTAL  = 10;
    localparam int VBP      = 3;
    localparam int VFP      = 8;
    localparam int H_ACTIVE = 6;
    localparam int H_TOTAL  = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic       HD;
    logic       DEN_H;
    logic       VD;
    logic       DEN;
    logic [3:0] LINE;
    logic [2:0] ROW;
    logic [2:0] COL;
    logic       FRAME_START;
`ifdef HD_WATCHDOG_EN
    logic       HD_LOST;
`endif

    int         total = 0;
    int         bad = 0;
    int         den_cycles = 0;
    int         line_changes = 0;
    int         frame_gap = 0;
    logic [3:0] prev_line = 4'd9;

    always #5 clock = ~clock;

    lcd_vtiming #(
        .V_TOTAL  (V_TOTAL),
        .VBP      (VBP),
        .VFP      (VFP),
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .HD          (HD),
        .DEN_H       (DEN_H),
        .VD          (VD),
        .DEN         (DEN),
        .LINE        (LINE),
        .ROW         (ROW),
        .COL         (COL),
`ifdef HD_WATCHDOG_EN
        .HD_LOST     (HD_LOST),
`endif
        .FRAME_START (FRAME_START)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (DEN === 1'b1) den_cycles++;
        if (LINE !== prev_line) line_changes++;
        prev_line = LINE;
        if (FRAME_START === 1'b1) begin
            frame_gap    = line_changes;
            line_changes = 0;
        end
    endtask

    task automatic idle(input int n);
        HD    = 1'b1;
        DEN_H = 1'b0;
        repeat (n) step();
    endtask

    task automatic run_line(input int den_len);
        HD    = 1'b0;
        DEN_H = 1'b0;
        step();
        HD    = 1'b1;
        step();
        DEN_H = 1'b1;
        repeat (den_len) step();
        DEN_H = 1'b0;
        repeat (H_TOTAL - 2 - den_len) step();
    endtask

    initial begin
        reset = 1'b1;
        HD    = 1'b1;
        DEN_H = 1'b0;
        #2;
        reset = 1'b0;
        repeat (3) step();
        check("rst_line", LINE, 9);
        check("rst_vd", VD, 1);
        check("rst_den", DEN, 0);
        check("rst_row", ROW, 0);
        check("rst_col", COL, 0);
        check("rst_fs", FRAME_START, 0);
        reset = 1'b1;
        idle(2);

        // First HD pulse starts line 0
        HD = 1'b0;
        step();
        check("l0_line", LINE, 0);
        check("l0_vd", VD, 0);
        check("l0_fs", FRAME_START, 1);
        HD = 1'b1;
        step();
        check("l0_fs_drop", FRAME_START, 0);
        check("l0_vd_hold", VD, 0);
        idle(10);

        HD = 1'b0;
        step();
        check("l1_line", LINE, 1);
        check("l1_vd", VD, 1);
        check("l1_fs", FRAME_START, 0);
        idle(11);

        den_cycles = 0;
        run_line(6);
        check("back_den", den_cycles, 0);

        // Line 3: first active line
        HD = 1'b0;
        step();
        check("l3_line", LINE, 3);
        check("l3_row", ROW, 0);
        check("l3_den_pre", DEN, 0);
        HD    = 1'b1;
        DEN_H = 1'b1;
        step();
        check("l3_den_rise", DEN, 1);
        check("l3_col0", COL, 0);
        step();
        check("l3_col1", COL, 1);
        repeat (4) step();
        check("l3_col5", COL, 5);
        DEN_H = 1'b0;
        step();
        check("l3_den_fall", DEN, 0);
        check("l3_col_clr", COL, 0);
        idle(4);

        // Line 4: HD held low 5 clocks, DEN_H over-long
        HD = 1'b0;
        repeat (5) step();
        check("hd_hold_line", LINE, 4);
        HD    = 1'b1;
        DEN_H = 1'b1;
        repeat (9) step();
        check("col_sat", COL, 5);
        check("l4_row", ROW, 1);
        check("l4_den", DEN, 1);
        DEN_H = 1'b0;
        step();
        idle(2);

        den_cycles = 0;
        run_line(6);
        run_line(6);
        run_line(6);
        check("act_den_cnt", den_cycles, 18);
        check("l7_line", LINE, 7);

        // Leave ACTIVE with DEN_H still high
        DEN_H = 1'b1;
        step();
        check("l7_den", DEN, 1);
        check("l7_row", ROW, 4);
        HD = 1'b0;
        step();
        check("fp_line", LINE, 8);
        check("fp_den_drop", DEN, 0);
        check("fp_row", ROW, 0);
        check("fp_col", COL, 0);
        idle(10);

        den_cycles = 0;
        run_line(6);
        check("fp_den_cnt", den_cycles, 0);

        // Wrap 9 -> 0
        HD = 1'b0;
        step();
        check("wrap_line", LINE, 0);
        check("wrap_vd", VD, 0);
        check("wrap_fs", FRAME_START, 1);
        check("frame_gap", frame_gap, 10);
        idle(11);

        // Asynchronous reset while DEN is high on line 3
        run_line(0);
        run_line(0);
        HD = 1'b0;
        step();
        HD    = 1'b1;
        DEN_H = 1'b1;
        step();
        step();
        check("mid_den", DEN, 1);
        check("mid_col", COL, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_den", DEN, 0);
        check("arst_col", COL, 0);
        check("arst_row", ROW, 0);
        check("arst_line", LINE, 9);
        check("arst_vd", VD, 1);
        DEN_H = 1'b0;
        step();
        reset = 1'b1;
        idle(2);
        HD = 1'b0;
        step();
        check("restart_line", LINE, 0);
        check("restart_fs", FRAME_START, 1);
        HD = 1'b1;
        step();

`ifdef HD_WATCHDOG_EN
        // Timeout fires 2*H_TOTAL clocks after the last event
        repeat (2 * H_TOTAL - 2) step();
        check("wd_not_yet", HD_LOST, 0);
        step();
        check("wd_lost", HD_LOST, 1);
        step();
        check("wd_line", LINE, 9);
        check("wd_den", DEN, 0);
        HD = 1'b0;
        step();
        check("wd_resume_line", LINE, 0);
        check("wd_resume_clr", HD_LOST, 0);
        HD = 1'b1;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
